// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: controller FSM states, register-index width,
// and the NOP/bubble encoding the pipeline buffers capture on flush or stall.
// Used by pipe_ctrl, hazard_detect and the pipeline buffer registers.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  // sll $0,$0,0: an all-zero word is a true no-op, so buffers simply clear
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic        BUBBLE_VAL = 1'b0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination of a load in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the stall logic of pipe_ctrl.
module hazard_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_memread,
  output logic             lu_hazard
);

  logic rs_match;
  logic rt_match;

  // $zero is never written, so a load targeting it cannot create a dependency
  always_comb begin
    rs_match  = id_use_rs && (id_rs == ex_dest);
    rt_match  = id_use_rt && (id_rt == ex_dest);
    lu_hazard = ex_memread && (ex_dest != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use bubble, redirect squash, memory-wait freeze, halt.
// Latency: stage controls are combinational (Mealy) from registered state; state, wait counter and mem_err are registered.
// Backpressure: a pending data-memory access freezes every stage; optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W       = pipe_pkg::REG_W,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_load,
  output logic             pc_sel_redirect,
  output logic             ifid_load,
  output logic             ifid_flush,
  output logic             idex_load,
  output logic             idex_stall,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             mem_err,
  output logic             halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count,
  output logic [31:0]      wait_cycles
`endif
);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             lu_hazard;
  logic             freeze;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_dest    (ex_dest),
    .ex_memread (ex_memread),
    .lu_hazard  (lu_hazard)
  );

  assign freeze  = mem_req & ~mem_ready;
  assign mem_err = mem_err_q;

  // State register plus wait counter and sticky error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next state: halt beats freeze in RUN; MEM_WAIT ignores halt and only exits on mem_ready
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (freeze) begin
          state_d = MEM_WAIT;
          cnt_d   = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        // Error is only flagged; the FSM keeps waiting for the memory
        if (cnt_q >= TMO_W'(MEM_TIMEOUT)) mem_err_d = 1'b1;
        if (mem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Stage controls: everything held outside RUN; in RUN priority is halt, freeze, redirect, load-use
  always_comb begin
    pc_load         = 1'b0;
    pc_sel_redirect = 1'b0;
    ifid_load       = 1'b0;
    ifid_flush      = 1'b0;
    idex_load       = 1'b0;
    idex_stall      = 1'b0;
    exmem_load      = 1'b0;
    memwb_load      = 1'b0;
    halted          = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (!halt_req && !freeze) begin
            idex_load  = 1'b1;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
            if (ex_redirect) begin
              // Younger instructions are squashed, so a load-use in ID is moot
              pc_load         = 1'b1;
              pc_sel_redirect = 1'b1;
              ifid_load       = 1'b1;
              ifid_flush      = 1'b1;
              idex_stall      = 1'b1;
            end else if (lu_hazard) begin
              // Hold PC and IF/ID for one cycle; the load moves to MEM and forwarding covers the rest
              idex_stall = 1'b1;
            end else begin
              pc_load   = 1'b1;
              ifid_load = 1'b1;
            end
          end
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q, wait_cycles_q;
  logic        wait_cyc;

  assign wait_cyc     = ~reset & ((state_q == MEM_WAIT) | ((state_q == RUN) & ~halt_req & freeze));
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
  assign wait_cycles  = wait_cycles_q;

  // Event counters; a bubble is a stall without a redirect, and all wrap naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      wait_cycles_q  <= '0;
    end else begin
      if (idex_stall && !pc_sel_redirect) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (pc_sel_redirect)                flush_count_q  <= flush_count_q + 32'd1;
      if (wait_cyc)                       wait_cycles_q  <= wait_cycles_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios followed by random traffic.
// A behavioural model predicts each cycle's controls and queues them; a monitor compares at the falling edge.
module tb_pipe_ctrl;

  localparam int TMO = 200;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_dest;
  logic       id_use_rs, id_use_rt, ex_memread, ex_redirect;
  logic       mem_req, mem_ready, halt_req;
  logic       pc_load, pc_sel_redirect, ifid_load, ifid_flush;
  logic       idex_load, idex_stall, exmem_load, memwb_load;
  logic       mem_err, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count, wait_cycles;
`endif

  always #5 clock = ~clock;

  pipe_ctrl #(.REG_W(5), .TMO_W(8), .MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_dest(ex_dest), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_load(pc_load), .pc_sel_redirect(pc_sel_redirect),
    .ifid_load(ifid_load), .ifid_flush(ifid_flush),
    .idex_load(idex_load), .idex_stall(idex_stall),
    .exmem_load(exmem_load), .memwb_load(memwb_load),
    .mem_err(mem_err), .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .wait_cycles(wait_cycles)
`endif
  );

  // ctrl bit order: pc_load, pc_sel_redirect, ifid_load, ifid_flush, idex_load, idex_stall, exmem_load, memwb_load
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_RUN   = 8'b1010_1011;
  localparam logic [7:0] C_REDIR = 8'b1111_1111;
  localparam logic [7:0] C_LU    = 8'b0000_1111;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic        err;
    logic        hlt;
    logic [31:0] st;
    logic [31:0] fl;
    logic [31:0] wt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: 0 = running, 1 = waiting on memory, 2 = halted
  int          m_mode = 0;
  int          m_wait = 0;
  bit          m_err  = 1'b0;
  bit [31:0]   m_st = 0, m_fl = 0, m_wt = 0;

  task automatic clr();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_dest = 0; ex_memread = 0; ex_redirect = 0;
    mem_req = 0; mem_ready = 0; halt_req = 0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, advance the model one clock
  task automatic step();
    exp_t e;
    bit   reads_load, mem_busy;
    e      = '0;
    e.err  = m_err;
    e.st   = m_st;
    e.fl   = m_fl;
    e.wt   = m_wt;
    reads_load = ex_memread && (ex_dest != 0) &&
                 ((id_use_rs && id_rs == ex_dest) || (id_use_rt && id_rt == ex_dest));
    mem_busy   = mem_req && !mem_ready;
    if (reset) begin
      m_mode = 0; m_wait = 0; m_err = 0; m_st = 0; m_fl = 0; m_wt = 0;
    end else if (m_mode == 2) begin
      e.hlt = 1'b1;
    end else if (m_mode == 1) begin
      m_wt = m_wt + 1;
      if (m_wait >= TMO) m_err = 1'b1;
      if (mem_ready) begin
        m_mode = 0; m_wait = 0;
      end else if (m_wait < 255) begin
        m_wait = m_wait + 1;
      end
    end else if (halt_req) begin
      m_mode = 2;
    end else if (mem_busy) begin
      m_mode = 1; m_wait = 1; m_wt = m_wt + 1;
    end else if (ex_redirect) begin
      e.ctrl = C_REDIR; m_fl = m_fl + 1;
    end else if (reads_load) begin
      e.ctrl = C_LU; m_st = m_st + 1;
    end else begin
      e.ctrl = C_RUN;
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result to check
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl", {24'd0, pc_load, pc_sel_redirect, ifid_load, ifid_flush,
                     idex_load, idex_stall, exmem_load, memwb_load}, {24'd0, e.ctrl});
        chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
        chk("halted",  {31'd0, halted},  {31'd0, e.hlt});
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_cycles", stall_cycles, e.st);
        chk("flush_count",  flush_count,  e.fl);
        chk("wait_cycles",  wait_cycles,  e.wt);
`endif
      end
    end
  end

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clock);
    #1;
    step(); step();
    reset = 1'b0;
    step();

    // Load-use: one bubble, then free flow
    ex_memread = 1; ex_dest = 8; id_rs = 8; id_use_rs = 1; step();
    clr(); step();

    // Load into $zero never stalls
    ex_memread = 1; ex_dest = 0; id_rs = 0; id_use_rs = 1; step();
    clr();

    // Redirect overrides a simultaneous load-use
    ex_redirect = 1; ex_memread = 1; ex_dest = 8; id_rt = 8; id_use_rt = 1; step();
    clr(); step();

    // Short memory wait: 5 busy cycles then completion
    mem_req = 1; repeat (5) step();
    mem_ready = 1; step(); step();
    clr(); step();

    // Timeout: mem_err rises and stays after completion until reset
    mem_req = 1; repeat (205) step();
    mem_ready = 1; step();
    clr(); repeat (3) step();
    reset = 1; step();
    reset = 0; step();

    // Reset in the middle of a wait
    mem_req = 1; repeat (3) step();
    reset = 1; step();
    reset = 0; clr(); step();

    // Halt is terminal until reset, and ignored during a wait
    halt_req = 1; step();
    halt_req = 0; ex_redirect = 1; repeat (8) step();
    clr(); reset = 1; step();
    reset = 0; step();
    mem_req = 1; step();
    halt_req = 1; step();
    mem_ready = 1; step();
    halt_req = 0; clr(); step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      halt_req    = ($urandom_range(0, 79) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = $urandom_range(0, 1);
      ex_redirect = ($urandom_range(0, 7) == 0);
      ex_memread  = ($urandom_range(0, 2) == 0);
      ex_dest     = 5'($urandom_range(0, 3));
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_use_rs   = $urandom_range(0, 1);
      id_use_rt   = $urandom_range(0, 1);
      step();
    end

    clr();
    reset = 0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
